// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the status-LED sequencer: command modes, FSM states, default tick length.
// The PAUSE state exists only when BURST_REPEAT_EN is defined.
package led_ctrl_pkg;

   localparam int TICK_MAX_DEFAULT = 24_999_999;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_BURST = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOLID,
      ST_BLINK,
      ST_BURST_ON,
      ST_BURST_OFF
`ifdef BURST_REPEAT_EN
      , ST_PAUSE
`endif
   } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running half-period tick: counts 0..TICK_MAX and pulses tick at the terminal count.
// restart forces the count back to 0 so the first tick lands TICK_MAX+1 cycles later.
module led_tick_gen
   import led_ctrl_pkg::*;
#(
   parameter int TICK_MAX = TICK_MAX_DEFAULT
) (
   input  logic clk,
   input  logic clear_n,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         count <= '0;
      end else if (restart || (count == CW'(TICK_MAX))) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == CW'(TICK_MAX));

endmodule

// File: rtl/led_pattern_ctrl.sv
// Command-driven status-LED sequencer (OFF / ON / BLINK / BURST) with registered outputs.
// Optional macro BURST_REPEAT_EN adds a PAUSE state that re-runs the last burst forever.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | LED dark, ticks ignored, ready for a command
// ST_SOLID     | LED lit steadily, ticks ignored
// ST_BLINK     | LED toggles on every tick
// ST_BURST_ON  | lit half of a counted blink, not ready
// ST_BURST_OFF | dark half of a counted blink, not ready
// ST_PAUSE     | (repeat build) dark gap before the burst restarts
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_MAX = TICK_MAX_DEFAULT,
   parameter int CNT_W    = 4
`ifdef BURST_REPEAT_EN
   , parameter int PAUSE_TICKS = 4
`endif
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [CNT_W-1:0] cmd_count,
   output logic             led_out,
   output logic             busy,
   output logic             done
);

   state_e           state, state_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic             led_nxt, busy_nxt, done_nxt;
   logic             accept, tick;
   mode_e            mode;

`ifdef BURST_REPEAT_EN
   localparam int PW = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;
   logic [CNT_W-1:0] burst_len, burst_len_nxt;
   logic [PW-1:0]    pause_cnt, pause_cnt_nxt;
`endif

   assign mode   = mode_e'(cmd_mode);
   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      cmd_ready = 1'b0;
      case (state)
         ST_IDLE, ST_SOLID, ST_BLINK: cmd_ready = 1'b1;
`ifdef BURST_REPEAT_EN
         ST_PAUSE:                    cmd_ready = 1'b1;
`endif
         default:                     cmd_ready = 1'b0;
      endcase
   end

   led_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick_gen (
      .clk     (clk),
      .clear_n (clear_n),
      .restart (accept),
      .tick    (tick)
   );

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         led_out   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef BURST_REPEAT_EN
         burst_len <= '0;
         pause_cnt <= '0;
`endif
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
         led_out   <= led_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
`ifdef BURST_REPEAT_EN
         burst_len <= burst_len_nxt;
         pause_cnt <= pause_cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt     = state;
      burst_cnt_nxt = burst_cnt;
      led_nxt       = led_out;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
`ifdef BURST_REPEAT_EN
      burst_len_nxt = burst_len;
      pause_cnt_nxt = pause_cnt;
`endif
      if (accept) begin
         busy_nxt = 1'b0;
         case (mode)
            MODE_OFF: begin
               state_nxt = ST_IDLE;
               led_nxt   = 1'b0;
            end
            MODE_ON: begin
               state_nxt = ST_SOLID;
               led_nxt   = 1'b1;
            end
            MODE_BLINK: begin
               state_nxt = ST_BLINK;
               led_nxt   = 1'b1;
            end
            default: begin
               if (cmd_count != '0) begin
                  state_nxt     = ST_BURST_ON;
                  led_nxt       = 1'b1;
                  busy_nxt      = 1'b1;
                  burst_cnt_nxt = cmd_count;
`ifdef BURST_REPEAT_EN
                  burst_len_nxt = cmd_count;
`endif
               end else begin
                  // Empty burst completes at once: report done without ever going busy.
                  state_nxt = ST_IDLE;
                  led_nxt   = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         endcase
      end else if (tick) begin
         case (state)
            ST_BLINK: led_nxt = ~led_out;
            ST_BURST_ON: begin
               state_nxt = ST_BURST_OFF;
               led_nxt   = 1'b0;
            end
            ST_BURST_OFF: begin
               burst_cnt_nxt = burst_cnt - CNT_W'(1);
               if (burst_cnt == CNT_W'(1)) begin
                  busy_nxt = 1'b0;
                  done_nxt = 1'b1;
`ifdef BURST_REPEAT_EN
                  state_nxt     = ST_PAUSE;
                  pause_cnt_nxt = PW'(PAUSE_TICKS);
`else
                  state_nxt = ST_IDLE;
`endif
               end else begin
                  state_nxt = ST_BURST_ON;
                  led_nxt   = 1'b1;
               end
            end
`ifdef BURST_REPEAT_EN
            ST_PAUSE: begin
               if (pause_cnt <= PW'(1)) begin
                  state_nxt     = ST_BURST_ON;
                  led_nxt       = 1'b1;
                  busy_nxt      = 1'b1;
                  burst_cnt_nxt = burst_len;
               end else begin
                  pause_cnt_nxt = pause_cnt - PW'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_MAX=3 (4-cycle tick period).
// Per-cycle vector table plus hand-written reset-abort and repeat sequences.
module tb_led_pattern_ctrl;

   localparam int TM = 3;
   localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_BURST = 2'b11;

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_mode = 2'b00;
   logic [3:0] cmd_count = 4'd0;
   logic       led_out, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       valid;
      logic [1:0] mode;
      logic [3:0] count;
      logic       led;
      logic       busy;
      logic       done;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   led_pattern_ctrl #(.TICK_MAX(TM), .CNT_W(4)) dut (
      .clk       (clk),
      .clear_n   (clear_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_count (cmd_count),
      .led_out   (led_out),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [1:0] m, input logic [3:0] c,
                      input logic l, input logic b, input logic d, input logic r);
      vec_t e;
      e.valid = v; e.mode = m; e.count = c;
      e.led = l; e.busy = b; e.done = d; e.rdy = r;
      vecs.push_back(e);
   endtask

   initial begin
      // BLINK: toggles every 4 edges
      add(1, M_BLINK, 0, 1, 0, 0, 1);
      for (int e = 1; e <= 12; e++) add(0, M_OFF, 0, ((e / 4) % 2) == 0, 0, 0, 1);
      // BLINK, ON preempts at edge 6, OFF at edge 10
      add(1, M_BLINK, 0, 1, 0, 0, 1);
      for (int e = 1; e <= 5; e++) add(0, M_OFF, 0, e < 4, 0, 0, 1);
      add(1, M_ON, 0, 1, 0, 0, 1);
      for (int e = 7; e <= 9; e++) add(0, M_OFF, 0, 1, 0, 0, 1);
      add(1, M_OFF, 0, 0, 0, 0, 1);
      for (int e = 11; e <= 13; e++) add(0, M_OFF, 0, 0, 0, 0, 1);
      // BURST n=2, an ON command at edge 6 must be ignored
      add(1, M_BURST, 2, 1, 1, 0, 0);
      for (int e = 1; e <= 15; e++) add(e == 6, M_ON, 0, ((e / 4) % 2) == 0, 1, 0, 0);
      add(0, M_OFF, 0, 0, 0, 1, 1);
      add(0, M_OFF, 0, 0, 0, 0, 1);
      // BURST n=0: immediate done, never busy
      add(1, M_BURST, 0, 0, 0, 1, 1);
      add(0, M_OFF, 0, 0, 0, 0, 1);
      add(0, M_OFF, 0, 0, 0, 0, 1);
      // BURST n=1: shortest burst, done at edge 8
      add(1, M_BURST, 1, 1, 1, 0, 0);
      for (int e = 1; e <= 7; e++) add(0, M_OFF, 0, e < 4, 1, 0, 0);
      add(0, M_OFF, 0, 0, 0, 1, 1);
      add(0, M_OFF, 0, 0, 0, 0, 1);

      // reset values while held in reset
      #12;
      check("rst_led", led_out, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      clear_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_led", led_out, 1'b0);
         check("idle_busy", busy, 1'b0);
         check("idle_done", done, 1'b0);
         check("idle_rdy", cmd_ready, 1'b1);
      end

      foreach (vecs[i]) begin
         cmd_valid = vecs[i].valid;
         cmd_mode  = vecs[i].mode;
         cmd_count = vecs[i].count;
         @(negedge clk);
         check($sformatf("v%0d_led", i), led_out, vecs[i].led);
         check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("v%0d_done", i), done, vecs[i].done);
         check($sformatf("v%0d_rdy", i), cmd_ready, vecs[i].rdy);
      end

      // BURST n=3 aborted by reset after edge 8
      cmd_valid = 1'b1; cmd_mode = M_BURST; cmd_count = 4'd3;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_mode = M_OFF; cmd_count = 4'd0;
      for (int e = 1; e <= 8; e++) @(negedge clk);
      check("abort_pre_led", led_out, 1'b1);
      check("abort_pre_busy", busy, 1'b1);
      #1 clear_n = 1'b0;
      #1;
      check("abort_led", led_out, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk);
      clear_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("post_abort_done", done, 1'b0);
         check("post_abort_rdy", cmd_ready, 1'b1);
         check("post_abort_led", led_out, 1'b0);
      end

`ifdef BURST_REPEAT_EN
      cmd_valid = 1'b1; cmd_mode = M_BURST; cmd_count = 4'd1;
      for (int e = 0; e <= 24; e++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (e == 8) begin
            check("rep_done", done, 1'b1);
            check("rep_pause_rdy", cmd_ready, 1'b1);
         end
         if (e == 9 || e == 23) check("rep_gap_led", led_out, 1'b0);
         if (e == 23) check("rep_gap_busy", busy, 1'b0);
         if (e == 24) begin
            check("rep_restart_led", led_out, 1'b1);
            check("rep_restart_busy", busy, 1'b1);
         end
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Command-driven sequencer for a single status LED: accepts OFF / ON / BLINK / BURST commands over a valid-ready handshake and drives a registered led_out.
Contains its own half-period tick generator, default 0.5 s at 50 MHz.
Sits between the system control logic and the board LED pin.
Resolves LED ownership between steady, continuous and counted-burst patterns.

Parameters:
TICK_MAX, 24_999_999, terminal count of the tick counter; tick period = TICK_MAX+1 clk cycles; counter width = $clog2(TICK_MAX+1).
CNT_W, 4, width of the burst count field.
PAUSE_TICKS, 4, gap length in ticks between repeated bursts (used only with BURST_REPEAT_EN).

Ports:
clk  in  1  system clock, all logic on rising edge.
clear_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command this cycle.
cmd_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST.
cmd_count  in  CNT_W  number of blinks for BURST; ignored for other modes.
led_out  out  1  registered LED drive, 1 = lit.
busy  out  1  high while a burst is in progress.
done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (clear_n=0, async): state IDLE, led_out=0, busy=0, done=0, tick counter=0, burst counter=0. cmd_ready=1 once reset is released.
- States: IDLE, SOLID, BLINK, BURST_ON, BURST_OFF.
- cmd_ready=1 in IDLE, SOLID and BLINK; 0 in BURST_ON and BURST_OFF.
- Accept occurs when cmd_valid && cmd_ready at a clock edge. cmd_valid while not ready is ignored; there is no queueing.
- Tick counter behaviour:
  - Counts 0..TICK_MAX, wraps to 0; tick = (count==TICK_MAX).
  - Forced to 0 on every accept.
  - First tick after an accept occurs TICK_MAX+1 cycles later.
- Every accept takes effect at the accepting edge; there are no extra latency cycles. It preempts SOLID or BLINK.
  - OFF -> IDLE, led_out=0.
  - ON -> SOLID, led_out=1.
  - BLINK -> BLINK, led_out=1; led_out toggles on every tick.
  - BURST, count=n>0 -> BURST_ON, led_out=1, burst counter=n, busy=1.
  - BURST, count=0 -> IDLE, led_out=0, done=1 for one cycle, busy stays 0.
- BURST_ON on tick -> BURST_OFF, led_out=0.
- BURST_OFF on tick:
  - Burst counter decrements.
  - If it reaches 0: -> IDLE, busy=0, done=1 for one cycle.
  - Otherwise: -> BURST_ON, led_out=1.
- Burst total length = 2·n·(TICK_MAX+1) cycles from accept to the done edge.
- done is registered; it is 0 in all other cycles.
- IDLE and SOLID ignore ticks.
- Reset mid-burst aborts immediately: led_out=0 and no done pulse.

Optional Feature:
BURST_REPEAT_EN.
- Defined: on burst completion, done pulses and state enters PAUSE instead of IDLE.
  - In PAUSE: led_out=0, busy=0, cmd_ready=1.
  - After PAUSE_TICKS ticks, the burst restarts with the original n, as BURST_ON with busy=1.
  - Repeats indefinitely until a new command is accepted in PAUSE.
  - count=0 still goes to IDLE.
- Undefined: PAUSE state and its pause counter are absent; behaviour is exactly as above.

Decomposition:
- Package led_ctrl_pkg holds:
  - mode encoding typedef (MODE_OFF/ON/BLINK/BURST);
  - state enum;
  - default TICK_MAX constant.
- Sub-module led_tick_gen: parameter TICK_MAX; inputs clk, clear_n, restart; output tick.
- All FSM, burst-count and LED logic lives in led_pattern_ctrl.

Test Plan:
All scenarios use TICK_MAX=3, so tick period = 4 cycles.
1. Reset released, no command -> led_out=0, busy=0, done=0, cmd_ready=1 for 20 cycles.
2. BLINK accepted at edge 0 -> led_out=1 at edge 0; 0 at edge 4; 1 at edge 8; 0 at edge 12. cmd_ready stays 1.
3. BURST n=2 accepted at edge 0:
   - led_out: 1 at edge 0, 0 at edge 4, 1 at edge 8, 0 at edge 12.
   - done=1 only in the cycle after edge 16; busy=1 over edges 0..15.
   - cmd_valid asserted at edge 6 with mode ON is ignored; cmd_ready=0.
4. BURST n=0 -> done pulse at the accept edge, busy never 1, led_out=0.
5. BLINK, then ON accepted at edge 6 -> led_out=1 stays constant. Then OFF at edge 10 -> led_out=0 at edge 10.
6. BURST n=3, clear_n pulled low at edge 9 -> led_out, busy and done drop to 0 asynchronously. After release cmd_ready=1 and no done pulse occurs.
   - With BURST_REPEAT_EN: BURST n=1 -> done at edge 8; led_out returns to 1 at edge 24.
